cpu_clk_switch_ctrl: RTL and testbench



---
 rtl/cpu_clk_switch_ctrl_if.sv | 36 +++
 rtl/cpu_clk_switch_ctrl.sv | 144 ++++++++++++++
 tb/tb_cpu_clk_switch_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clk_switch_ctrl_if.sv
// Handshake bundle between the CPU clock-switch sequencer and its environment:
// switch requests and mux lock come in, mux select and CPU reset go out.
interface cpu_clk_switch_ctrl_if;
    logic       sel_req_valid;
    logic       sel_req;
    logic       locked;
    logic       clk_wiz_enable;
    logic       cpu_resetn;
    logic       busy;
    logic       switch_err;
    logic [7:0] lock_loss_cnt;

    // Requester / clock-mux side.
    modport master (
        output sel_req_valid,
        output sel_req,
        output locked,
        input  clk_wiz_enable,
        input  cpu_resetn,
        input  busy,
        input  switch_err,
        input  lock_loss_cnt
    );

    // Sequencer side.
    modport slave (
        input  sel_req_valid,
        input  sel_req,
        input  locked,
        output clk_wiz_enable,
        output cpu_resetn,
        output busy,
        output switch_err,
        output lock_loss_cnt
    );
endinterface

// File: rtl/cpu_clk_switch_ctrl.sv
// CPU clock-source switch sequencer. Runs on the never-switching sys_clock,
// holds the CPU in reset around every mux select change, waits for MMCM lock
// (falling back to sys_clock on timeout) and releases CPU reset only after
// lock has been continuously stable for RELEASE_CYCLES cycles.
module cpu_clk_switch_ctrl #(
    parameter int HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int RELEASE_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                  sys_clock,
    input  logic                  resetn,
    cpu_clk_switch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_STABLE     = 2'd0,
        ST_RUN        = 2'd1,
        ST_PRE_SWITCH = 2'd2,
        ST_WAIT_LOCK  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    // First WAIT_LOCK count at which locked_s reflects the new clock, not
    // whatever the synchronizer still held from before the switch.
    localparam logic [CNT_W-1:0] FLUSH_DONE = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             lock_meta_r;
    logic             locked_s;
    logic             sel_latch_r;
    logic             clk_wiz_enable_r;
    logic             cpu_resetn_r;
    logic             busy_r;
    logic             switch_err_r;
    logic [7:0]       lock_loss_cnt_r;

    // Two-flop synchronizer bringing the mux lock into the sys_clock domain.
    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            lock_meta_r <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            lock_meta_r <= bus.locked;
            locked_s    <= lock_meta_r;
        end
    end

    // Switch sequencer with registered select, CPU reset and status outputs.
    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            state_r          <= ST_STABLE;
            cnt_r            <= '0;
            sel_latch_r      <= 1'b0;
            clk_wiz_enable_r <= 1'b0;
            cpu_resetn_r     <= 1'b0;
            busy_r           <= 1'b1;
            switch_err_r     <= 1'b0;
            lock_loss_cnt_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_STABLE: begin
                    if (!locked_s) begin
                        // Any lock glitch restarts the stability window.
                        cnt_r <= '0;
                    end else if (cnt_r == REL_LAST) begin
                        state_r      <= ST_RUN;
                        cnt_r        <= '0;
                        cpu_resetn_r <= 1'b1;
                        busy_r       <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_RUN: begin
                    if (!locked_s) begin
                        // Lock loss wins over a simultaneous request.
                        state_r      <= ST_WAIT_LOCK;
                        cnt_r        <= '0;
                        cpu_resetn_r <= 1'b0;
                        busy_r       <= 1'b1;
                        if (lock_loss_cnt_r != 8'hFF) begin
                            lock_loss_cnt_r <= lock_loss_cnt_r + 8'd1;
                        end
                    end else if (bus.sel_req_valid) begin
                        switch_err_r <= 1'b0;
                        if (bus.sel_req != clk_wiz_enable_r) begin
                            sel_latch_r  <= bus.sel_req;
                            state_r      <= ST_PRE_SWITCH;
                            cnt_r        <= '0;
                            cpu_resetn_r <= 1'b0;
                            busy_r       <= 1'b1;
                        end
                    end
                end

                ST_PRE_SWITCH: begin
                    if (cnt_r == HOLD_LAST) begin
                        clk_wiz_enable_r <= sel_latch_r;
                        state_r          <= ST_WAIT_LOCK;
                        cnt_r            <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_WAIT_LOCK: begin
                    if ((cnt_r >= FLUSH_DONE) && locked_s) begin
                        state_r <= ST_STABLE;
                        cnt_r   <= '0;
                    end else if (cnt_r == TMO_LAST) begin
                        // Give up on the requested source and fall back.
                        clk_wiz_enable_r <= 1'b0;
                        switch_err_r     <= 1'b1;
                        state_r          <= ST_STABLE;
                        cnt_r            <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                default: begin
                    // Unreachable encoding: park the CPU in reset and resync.
                    state_r      <= ST_STABLE;
                    cnt_r        <= '0;
                    cpu_resetn_r <= 1'b0;
                    busy_r       <= 1'b1;
                end
            endcase
        end
    end

    assign bus.clk_wiz_enable = clk_wiz_enable_r;
    assign bus.cpu_resetn     = cpu_resetn_r;
    assign bus.busy           = busy_r;
    assign bus.switch_err     = switch_err_r;
    assign bus.lock_loss_cnt  = lock_loss_cnt_r;

endmodule

// File: tb/tb_cpu_clk_switch_ctrl.sv
// Directed bench for cpu_clk_switch_ctrl with HOLD_CYCLES=4, LOCK_TIMEOUT=200,
// RELEASE_CYCLES=8. Inputs change and outputs are sampled on the falling edge;
// "edge N" means the N-th rising edge after the stimulus change.
module tb_cpu_clk_switch_ctrl;

    localparam int HOLD = 4;
    localparam int TMO  = 200;
    localparam int REL  = 8;

    logic sys_clock;
    logic resetn;
    int   n_vec;
    int   n_err;

    cpu_clk_switch_ctrl_if bus ();

    cpu_clk_switch_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .LOCK_TIMEOUT  (TMO),
        .RELEASE_CYCLES(REL),
        .CNT_W         (16)
    ) dut (
        .sys_clock(sys_clock),
        .resetn   (resetn),
        .bus      (bus)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, ending on the following falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clock);
            @(negedge sys_clock);
        end
    endtask

    // One-cycle request strobe sampled by the next rising edge.
    task automatic request(input logic sel);
        bus.sel_req_valid = 1'b1;
        bus.sel_req       = sel;
        step(1);
        bus.sel_req_valid = 1'b0;
    endtask

    // Bounded wait for CPU reset release; expiry shows up as a failed check.
    task automatic wait_release(input int budget, input string tag);
        for (int i = 0; i < budget && bus.cpu_resetn !== 1'b1; i++) begin
            step(1);
        end
        check_vec(tag, 16'(bus.cpu_resetn), 16'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_vec({tag, "_en"},   16'(bus.clk_wiz_enable), 16'd0);
        check_vec({tag, "_rstn"}, 16'(bus.cpu_resetn),     16'd0);
        check_vec({tag, "_busy"}, 16'(bus.busy),           16'd1);
        check_vec({tag, "_err"},  16'(bus.switch_err),     16'd0);
        check_vec({tag, "_loss"}, 16'(bus.lock_loss_cnt),  16'd0);
    endtask

    initial begin
        n_vec             = 0;
        n_err             = 0;
        resetn            = 1'b0;
        bus.sel_req_valid = 1'b0;
        bus.sel_req       = 1'b0;
        bus.locked        = 1'b1;

        // Reset state, then release with lock present: sync 2 edges + 8 count.
        #12;
        check_reset_values("rst");
        @(negedge sys_clock);
        resetn = 1'b1;
        step(REL + 1);
        check_vec("rel_e9_rstn", 16'(bus.cpu_resetn), 16'd0);
        step(1);
        check_vec("rel_e10_rstn", 16'(bus.cpu_resetn), 16'd1);
        check_vec("rel_e10_busy", 16'(bus.busy), 16'd0);
        check_vec("rel_e10_en",   16'(bus.clk_wiz_enable), 16'd0);
        check_vec("rel_e10_err",  16'(bus.switch_err), 16'd0);
        check_vec("rel_e10_loss", 16'(bus.lock_loss_cnt), 16'd0);

        // Switch to clk_wiz; stray requests during PRE_SWITCH and WAIT_LOCK.
        request(1'b1);                                   // edge 0
        check_vec("sw1_e1_rstn", 16'(bus.cpu_resetn), 16'd0);
        check_vec("sw1_e1_busy", 16'(bus.busy), 16'd1);
        step(1);                                         // edge 1
        request(1'b0);                                   // edge 2, ignored
        check_vec("sw1_e2_en", 16'(bus.clk_wiz_enable), 16'd0);
        step(1);                                         // edge 3
        check_vec("sw1_e3_en", 16'(bus.clk_wiz_enable), 16'd0);
        step(1);                                         // edge 4
        check_vec("sw1_e4_en", 16'(bus.clk_wiz_enable), 16'd1);
        bus.locked = 1'b0;
        step(2);
        request(1'b0);                                   // ignored in WAIT_LOCK
        step(47);
        check_vec("sw1_wait_rstn", 16'(bus.cpu_resetn), 16'd0);
        check_vec("sw1_wait_en",   16'(bus.clk_wiz_enable), 16'd1);
        // Lock returns: 2 sync edges, 1 edge to leave WAIT_LOCK, 8 to release.
        bus.locked = 1'b1;
        step(REL + 2);
        check_vec("sw1_lk10_rstn", 16'(bus.cpu_resetn), 16'd0);
        step(1);
        check_vec("sw1_lk11_rstn", 16'(bus.cpu_resetn), 16'd1);
        check_vec("sw1_err", 16'(bus.switch_err), 16'd0);
        check_vec("sw1_en",  16'(bus.clk_wiz_enable), 16'd1);

        // Back to sys_clock with lock held throughout.
        request(1'b0);
        check_vec("sw0_rstn_low", 16'(bus.cpu_resetn), 16'd0);
        wait_release(60, "sw0_release");
        check_vec("sw0_en", 16'(bus.clk_wiz_enable), 16'd0);

        // Lock never comes: fallback 200 edges after entering WAIT_LOCK.
        request(1'b1);                                   // edge 0
        step(HOLD);                                      // edge 4
        check_vec("tmo_e4_en", 16'(bus.clk_wiz_enable), 16'd1);
        bus.locked = 1'b0;
        step(TMO - 1);
        check_vec("tmo_pre_en",  16'(bus.clk_wiz_enable), 16'd1);
        check_vec("tmo_pre_err", 16'(bus.switch_err), 16'd0);
        step(1);
        check_vec("tmo_en",   16'(bus.clk_wiz_enable), 16'd0);
        check_vec("tmo_err",  16'(bus.switch_err), 16'd1);
        check_vec("tmo_rstn", 16'(bus.cpu_resetn), 16'd0);
        bus.locked = 1'b1;
        step(REL + 1);
        check_vec("tmo_e9_rstn", 16'(bus.cpu_resetn), 16'd0);
        step(1);
        check_vec("tmo_e10_rstn", 16'(bus.cpu_resetn), 16'd1);
        check_vec("tmo_e10_err",  16'(bus.switch_err), 16'd1);

        // Same-source request in RUN only clears the error flag.
        request(1'b0);
        check_vec("same_err",  16'(bus.switch_err), 16'd0);
        check_vec("same_rstn", 16'(bus.cpu_resetn), 16'd1);
        step(3);
        check_vec("same_busy", 16'(bus.busy), 16'd0);
        check_vec("same_en",   16'(bus.clk_wiz_enable), 16'd0);

        // Lock loss in RUN for 20 cycles.
        bus.locked = 1'b0;
        step(2);
        check_vec("loss_e2_rstn", 16'(bus.cpu_resetn), 16'd1);
        step(1);
        check_vec("loss_e3_rstn", 16'(bus.cpu_resetn), 16'd0);
        check_vec("loss_e3_cnt",  16'(bus.lock_loss_cnt), 16'd1);
        step(17);
        bus.locked = 1'b1;
        step(REL + 2);
        check_vec("loss_lk10_rstn", 16'(bus.cpu_resetn), 16'd0);
        step(1);
        check_vec("loss_lk11_rstn", 16'(bus.cpu_resetn), 16'd1);
        check_vec("loss_en", 16'(bus.clk_wiz_enable), 16'd0);

        // Asynchronous reset in the middle of WAIT_LOCK with clk_wiz selected.
        request(1'b1);
        step(HOLD);
        check_vec("mid_en", 16'(bus.clk_wiz_enable), 16'd1);
        bus.locked = 1'b0;
        step(10);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("mid_rst");
        bus.locked = 1'b1;
        @(negedge sys_clock);
        resetn = 1'b1;
        step(REL + 1);
        check_vec("mid_e9_rstn", 16'(bus.cpu_resetn), 16'd0);
        step(1);
        check_vec("mid_e10_rstn", 16'(bus.cpu_resetn), 16'd1);

        // Repeated lock drops: counter saturates at 255.
        for (int d = 1; d <= 300; d++) begin
            bus.locked = 1'b0;
            step(4);
            bus.locked = 1'b1;
            wait_release(40, "sat_release");
            if (d == 10) begin
                check_vec("sat_cnt10", 16'(bus.lock_loss_cnt), 16'd10);
            end
        end
        check_vec("sat_cnt", 16'(bus.lock_loss_cnt), 16'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
